// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with a valid/ready handshake and a two-entry skid buffer.
// It also provides flush (bubble insertion) and a saturating count of stalled cycles.
module id_ex_skid_stage #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 133,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    // in_ready is combinational, so upstream learns in the same cycle that the skid slot is free.
    assign in_ready = ~rst & (state != FULL);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // NOTE: every register is assigned with <=, so each branch reads the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != {STAT_W{1'b1}})
                stall_cnt <= stall_cnt + {{(STAT_W-1){1'b0}}, 1'b1};

            if (flush) begin
                // out_data keeps its old value, so the bus stays stable while invalid.
                state     <= EMPTY;
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            state     <= ONE;
                            out_valid <= 1'b1;
                            out_ctrl  <= in_ctrl;
                            out_data  <= in_data;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            out_ctrl <= in_ctrl;
                            out_data <= in_data;
                        end else if (in_fire) begin
                            state     <= FULL;
                            skid_ctrl <= in_ctrl;
                            skid_data <= in_data;
                        end else if (out_fire) begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                            out_ctrl  <= '0;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            state    <= ONE;
                            out_ctrl <= skid_ctrl;
                            out_data <= skid_data;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
